// File: rtl/input_scan_debouncer.sv
// input_scan_debouncer
//   Shared debounce engine: each noisy input gets a two-flop synchronizer, then a single
//   round-robin scan pointer visits one channel per prescaler period and updates that
//   channel's stability counter. The conditioned level flips after WAITTIME consecutive
//   visits that disagree with it; a one-clock edge pulse accompanies each flip.
//
// Parameters
//   CHANNELS  number of noisy inputs (1..16)
//   WAITTIME  consecutive disagreeing visits before the level flips (1..15)
//   SCAN_DIV  clocks between successive channel visits (1..255)
//
// Ports
//   clk           system clock
//   reset_n       asynchronous active-low reset
//   enable        scan enable; low freezes prescaler, pointer and counters
//   noisysignal   raw asynchronous inputs
//   conditioned   debounced levels
//   positiveedge  one-clock pulse on a 0->1 conditioned transition
//   negativeedge  one-clock pulse on a 1->0 conditioned transition
//   scan_ptr      index of the channel being visited
//
// Optional build macro SCAN_DEBOUNCER_IRQ_EN adds:
//   irq_clear     write-one-to-clear mask for irq_pending
//   irq_pending   sticky per-channel flag, set by any edge pulse of that channel
//   irq           OR of irq_pending
module input_scan_debouncer #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WAITTIME = 3,
    parameter int unsigned SCAN_DIV = 2,
    localparam int unsigned PW = $clog2((CHANNELS > 1) ? CHANNELS : 2),
    localparam int unsigned CW = $clog2(WAITTIME + 1),
    localparam int unsigned DW = $clog2(SCAN_DIV + 1)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [CHANNELS-1:0] noisysignal,
    output logic [CHANNELS-1:0] conditioned,
    output logic [CHANNELS-1:0] positiveedge,
    output logic [CHANNELS-1:0] negativeedge,
    output logic [PW-1:0]       scan_ptr
`ifdef SCAN_DEBOUNCER_IRQ_EN
    ,
    input  logic [CHANNELS-1:0] irq_clear,
    output logic [CHANNELS-1:0] irq_pending,
    output logic                irq
`endif
);

    logic [CHANNELS-1:0] sync1_q, sync2_q;
    logic [CW-1:0]       count_q [CHANNELS];
    logic [CW-1:0]       count_d [CHANNELS];
    logic [DW-1:0]       presc_q, presc_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [CHANNELS-1:0] cond_q, cond_d;
    logic [CHANNELS-1:0] pos_q, pos_d;
    logic [CHANNELS-1:0] neg_q, neg_d;
    logic                visit;

    // Synchronizer runs regardless of enable so the sampled level is always fresh.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= noisysignal;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        visit = enable && (presc_q == DW'(SCAN_DIV - 1));

        presc_d = presc_q;
        if (enable) begin
            presc_d = visit ? '0 : presc_q + 1'b1;
        end

        ptr_d = ptr_q;
        if (visit) begin
            ptr_d = (ptr_q == PW'(CHANNELS - 1)) ? '0 : ptr_q + 1'b1;
        end

        count_d = count_q;
        cond_d  = cond_q;
        pos_d   = '0;
        neg_d   = '0;
        if (visit) begin
            // Compare against each index so the pointer never indexes out of range.
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (ptr_q == PW'(i)) begin
                    if (sync2_q[i] == cond_q[i]) begin
                        count_d[i] = '0;
                    end else if (count_q[i] == CW'(WAITTIME - 1)) begin
                        cond_d[i]  = sync2_q[i];
                        count_d[i] = '0;
                        pos_d[i]   = sync2_q[i];
                        neg_d[i]   = ~sync2_q[i];
                    end else begin
                        count_d[i] = count_q[i] + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
            ptr_q   <= '0;
            cond_q  <= '0;
            pos_q   <= '0;
            neg_q   <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                count_q[i] <= '0;
            end
        end else begin
            presc_q <= presc_d;
            ptr_q   <= ptr_d;
            cond_q  <= cond_d;
            pos_q   <= pos_d;
            neg_q   <= neg_d;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                count_q[i] <= count_d[i];
            end
        end
    end

    assign conditioned  = cond_q;
    assign positiveedge = pos_q;
    assign negativeedge = neg_q;
    assign scan_ptr     = ptr_q;

`ifdef SCAN_DEBOUNCER_IRQ_EN
    logic [CHANNELS-1:0] pend_q, pend_d;

    // Set term is OR-ed last so a new edge wins over a simultaneous clear.
    always_comb begin
        pend_d = (pend_q & ~irq_clear) | pos_q | neg_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign irq_pending = pend_q;
    assign irq         = |pend_q;
`endif

endmodule

// File: tb/tb_input_scan_debouncer.sv
// tb_input_scan_debouncer
//   Drives input_scan_debouncer with directed and randomized stimulus and compares every
//   clock against a reference model built from the visit rules: a visit happens on every
//   SCAN_DIV-th enabled clock, visits go to channels in order, and a channel's level
//   flips after WAITTIME consecutive disagreeing visits of its 2-clock-delayed input.
module tb_input_scan_debouncer;

    localparam int unsigned C  = 4;
    localparam int unsigned W  = 3;
    localparam int unsigned D  = 2;
    localparam int unsigned PW = 2;
    localparam int unsigned LAT_LO = 2 + (W - 1) * C * D + 1;
    localparam int unsigned LAT_HI = 2 + W * C * D;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          enable = 1'b0;
    logic [C-1:0]  noisysignal = '0;
    logic [C-1:0]  conditioned, positiveedge, negativeedge;
    logic [PW-1:0] scan_ptr;
`ifdef SCAN_DEBOUNCER_IRQ_EN
    logic [C-1:0]  irq_clear = '0;
    logic [C-1:0]  irq_pending;
    logic          irq;
`endif

    input_scan_debouncer #(
        .CHANNELS(C),
        .WAITTIME(W),
        .SCAN_DIV(D)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .noisysignal  (noisysignal),
        .conditioned  (conditioned),
        .positiveedge (positiveedge),
        .negativeedge (negativeedge),
        .scan_ptr     (scan_ptr)
`ifdef SCAN_DEBOUNCER_IRQ_EN
        ,
        .irq_clear    (irq_clear),
        .irq_pending  (irq_pending),
        .irq          (irq)
`endif
    );

    always #10 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [C-1:0] m_cond, m_pos, m_neg, m_pend;
    int unsigned  m_run [C];
    int unsigned  m_ticks, m_visits;
    logic [C-1:0] m_hist [$];

    always @(posedge clk or negedge reset_n) begin
        logic [C-1:0] s;
        int unsigned  ch;
        if (!reset_n) begin
            m_cond = '0;
            m_pos = '0;
            m_neg = '0;
            m_pend = '0;
            m_ticks = 0;
            m_visits = 0;
            for (int i = 0; i < C; i++) m_run[i] = 0;
            m_hist.delete();
            m_hist.push_back('0);
            m_hist.push_back('0);
        end else begin
            s = m_hist.pop_front();
            m_hist.push_back(noisysignal);
`ifdef SCAN_DEBOUNCER_IRQ_EN
            m_pend = (m_pend & ~irq_clear) | m_pos | m_neg;
`endif
            m_pos = '0;
            m_neg = '0;
            if (enable) begin
                if (m_ticks % D == D - 1) begin
                    ch = m_visits % C;
                    if (s[ch] == m_cond[ch]) begin
                        m_run[ch] = 0;
                    end else begin
                        m_run[ch]++;
                        if (m_run[ch] == W) begin
                            m_cond[ch] = s[ch];
                            m_pos[ch]  = s[ch];
                            m_neg[ch]  = !s[ch];
                            m_run[ch]  = 0;
                        end
                    end
                    m_visits++;
                end
                m_ticks++;
            end
        end
    end

    task automatic cmp_all();
        chk("cond", conditioned, m_cond);
        chk("pos", positiveedge, m_pos);
        chk("neg", negativeedge, m_neg);
        chk("ptr", scan_ptr, m_visits % C);
        chk("one_pulse", $countones(positiveedge | negativeedge) <= 1, 1);
`ifdef SCAN_DEBOUNCER_IRQ_EN
        chk("irq_pending", irq_pending, m_pend);
        chk("irq", irq, |m_pend);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cmp_all();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned pc [C];
        int unsigned n;
        int unsigned edges1;

        // Power-on reset, inputs high
        noisysignal = '1;
        enable = 1'b1;
        #1 reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (30) tick();

        // Asynchronous reset mid-cycle clears everything at once
        #3 reset_n = 1'b0;
        #1;
        chk("rst_cond", conditioned, 0);
        chk("rst_pos", positiveedge, 0);
        chk("rst_neg", negativeedge, 0);
        chk("rst_ptr", scan_ptr, 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < C; i++) pc[i] = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            for (int i = 0; i < C; i++) if (positiveedge[i]) pc[i]++;
            if (k == 25) chk("rst_all_high", conditioned, {C{1'b1}});
        end
        for (int i = 0; i < C; i++) chk("rst_pulse_count", pc[i], 1);

        // Clean step on channel 2
        noisysignal = '0;
        repeat (40) tick();
        noisysignal[2] = 1'b1;
        n = 0;
        while (!conditioned[2] && n < 100) begin
            tick();
            n++;
        end
        chk("step_lat_ok", (n >= LAT_LO) && (n <= LAT_HI), 1);
        chk("step_pulse", positiveedge, 4'b0100);
        chk("step_others", conditioned, 4'b0100);

        // A 6-clock bounce period never lines up WAITTIME disagreeing visits
        edges1 = 0;
        for (int k = 0; k < 102; k++) begin
            if (k % 3 == 0) noisysignal[1] = ~noisysignal[1];
            tick();
            if (positiveedge[1] || negativeedge[1]) edges1++;
        end
        chk("bounce_cond1", conditioned[1], 0);
        chk("bounce_edges", edges1, 0);
        noisysignal[1] = 1'b1;
        n = 0;
        while (!conditioned[1] && n < 100) begin
            tick();
            n++;
        end
        chk("bounce_settle_ok", n <= LAT_HI, 1);

        // Falling edge on channel 3 after it has gone high
        noisysignal[3] = 1'b1;
        repeat (40) tick();
        chk("ch3_high", conditioned[3], 1);
        noisysignal[3] = 1'b0;
        n = 0;
        while (!negativeedge[3] && n < 100) begin
            tick();
            n++;
        end
        chk("neg3_seen", negativeedge[3], 1);
        tick();
        chk("neg3_single", negativeedge[3], 0);

        // Freeze with channel 0 partially counted
        noisysignal[0] = 1'b1;
        n = 0;
        while (m_run[0] != 1 && n < 100) begin
            tick();
            n++;
        end
        chk("freeze_partial", m_run[0], 1);
        enable = 1'b0;
        repeat (40) tick();
        chk("freeze_ptr", scan_ptr, 1);
        chk("freeze_cond0", conditioned[0], 0);
        enable = 1'b1;
        n = 0;
        while (!conditioned[0] && n < 100) begin
            tick();
            n++;
        end
        chk("resume_lat_ok", (n > (W - 2) * C * D) && (n <= (W - 1) * C * D), 1);

        // Randomized soak: slow/fast toggling, enable gaps, occasional resets
        for (int k = 0; k < 4000; k++) begin
            for (int i = 0; i < C; i++)
                if ($urandom_range(0, 29) == 0) noisysignal[i] = ~noisysignal[i];
            enable = ($urandom_range(0, 15) != 0);
`ifdef SCAN_DEBOUNCER_IRQ_EN
            irq_clear = ($urandom_range(0, 3) == 0) ? C'($urandom) : '0;
`endif
            reset_n = ($urandom_range(0, 499) != 0);
            tick();
            reset_n = 1'b1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
